// File: rtl/bayer_gray_bin.sv
// Bins each 2x2 Bayer quad (G1 R / B G2) of a raw 12-bit stream into one 12-bit gray pixel.
// Latency: one cycle from the sampling edge of G2 to the oDVAL strobe.
// Backpressure: none; a sink must accept every oDVAL strobe. iDVAL gaps anywhere are tolerated.
// Optional macro GRAY_LUMA_EN selects weighted luma (4R+5G1+5G2+2B)/16 instead of the plain average.
module bayer_gray_bin #(
    parameter int LINE_WIDTH = 640,
    parameter int XW         = 16
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic [11:0]   iDATA,
    input  logic          iDVAL,
    input  logic [XW-1:0] iX_Cont,
    input  logic [XW-1:0] iY_Cont,
    output logic [11:0]   oDATA,
    output logic          oDVAL,
    output logic [XW-1:0] oX_Cont,
    output logic [XW-1:0] oY_Cont
);

    localparam int            DEPTH = LINE_WIDTH / 2;
    localparam int            AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [XW-1:0] LW    = XW'(LINE_WIDTH);

    // Half-line buffer of {G1, R} pairs from the most recent even row.
    logic [23:0]   r_mem [DEPTH];
    logic [23:0]   r_rd_dat;
    logic [11:0]   r_even_pix;
    logic          r_even_vld;
    logic          r_row_primed;
    logic [11:0]   r_odata;
    logic          r_odvl;
    logic [XW-1:0] r_ox;
    logic [XW-1:0] r_oy;

    logic          w_acc;
    logic          w_even;
    logic          w_odd_pair;
    logic          w_wr;
    logic          w_rd;
    logic          w_quad;
    logic [AW-1:0] w_addr;
    logic [11:0]   w_g1;
    logic [11:0]   w_r;
    logic [11:0]   w_b;
    logic [11:0]   w_g2;
    logic [11:0]   w_gray;

    // Pixel acceptance and pairing decode.
    assign w_acc      = iDVAL && (iX_Cont < LW);
    assign w_even     = w_acc && !iX_Cont[0];
    assign w_odd_pair = w_acc && iX_Cont[0] && r_even_vld;
    assign w_wr       = w_odd_pair && !iY_Cont[0];
    assign w_rd       = w_even && iY_Cont[0];
    assign w_quad     = w_odd_pair && iY_Cont[0] && r_row_primed;
    assign w_addr     = iX_Cont[AW:1];

    // Quad members: top pair from the buffer, bottom pair from the held even pixel and live input.
    assign w_g1 = r_rd_dat[23:12];
    assign w_r  = r_rd_dat[11:0];
    assign w_b  = r_even_pix;
    assign w_g2 = iDATA;

`ifdef GRAY_LUMA_EN
    logic [15:0] w_luma;
    // 16-bit weighted sum cannot overflow: the weights add up to 16.
    assign w_luma = ({4'd0, w_r}  << 2)
                  + ({4'd0, w_g1} << 2) + {4'd0, w_g1}
                  + ({4'd0, w_g2} << 2) + {4'd0, w_g2}
                  + ({4'd0, w_b}  << 1);
    assign w_gray = w_luma[15:4];
`else
    logic [13:0] w_sum;
    // 14-bit sum of four 12-bit samples cannot overflow; truncating divide by 4.
    assign w_sum  = {2'd0, w_g1} + {2'd0, w_r} + {2'd0, w_b} + {2'd0, w_g2};
    assign w_gray = w_sum[13:2];
`endif

    // Line buffer: even rows write, odd rows read, so the same address never collides on one edge.
    always_ff @(posedge iCLK) begin
        if (w_wr) r_mem[w_addr] <= {r_even_pix, iDATA};
        if (w_rd) r_rd_dat      <= r_mem[w_addr];
    end

    // Column pairing state and row-primed flag gating use of the uninitialised buffer.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_even_pix   <= '0;
            r_even_vld   <= 1'b0;
            r_row_primed <= 1'b0;
        end else begin
            if (w_even) begin
                r_even_pix <= iDATA;
                r_even_vld <= 1'b1;
            end else if (w_odd_pair) begin
                r_even_vld <= 1'b0;
            end
            if (w_wr) r_row_primed <= 1'b1;
        end
    end

    // Output stage: strobe for one cycle per completed quad, hold data and coordinates otherwise.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_odata <= '0;
            r_odvl  <= 1'b0;
            r_ox    <= '0;
            r_oy    <= '0;
        end else begin
            r_odvl <= w_quad;
            if (w_quad) begin
                r_odata <= w_gray;
                r_ox    <= iX_Cont >> 1;
                r_oy    <= iY_Cont >> 1;
            end
        end
    end

    assign oDATA   = r_odata;
    assign oDVAL   = r_odvl;
    assign oX_Cont = r_ox;
    assign oY_Cont = r_oy;

endmodule

// File: doc/bayer_gray_bin.md
Name: bayer_gray_bin

Overview:
- Upstream neighbour of the Sobel edge stage; sits between the CCD capture block and the edge filter.
- Bins each 2x2 Bayer quad (G1 R / B G2) of the raw 12-bit stream into one 12-bit grayscale pixel.
- The edge filter therefore sees a true luminance image at half resolution, not a mosaic.
- Uses one half-line pair buffer, column-pairing state and a one-stage output pipeline.

Parameters:
- LINE_WIDTH, 640: input pixels per row (even); buffer depth is LINE_WIDTH/2 words of 24 bits.
- XW, 16: width of the X/Y counter ports.

Ports:
- iCLK  in  1  pixel clock
- iRST  in  1  asynchronous active-low reset
- iDATA  in  12  raw Bayer pixel
- iDVAL  in  1  iDATA/iX_Cont/iY_Cont valid this cycle
- iX_Cont  in  XW  input column
- iY_Cont  in  XW  input row
- oDATA  out  12  binned gray pixel
- oDVAL  out  1  one-cycle strobe, oDATA valid
- oX_Cont  out  XW  iX_Cont>>1 of the producing quad
- oY_Cont  out  XW  iY_Cont>>1 of the producing quad

Behaviour:
- Reset (async, iRST low): oDATA=0, oDVAL=0, oX_Cont=0, oY_Cont=0.
- Reset also clears even_pix_valid, row_primed and the output pipe.
- Line buffer RAM is not cleared; row_primed gates its use.
- A pixel is accepted only on a rising edge with iDVAL=1 and iX_Cont<LINE_WIDTH. Other pixels are ignored; no write, no output.
- Even column (iX_Cont[0]=0):
  - latch iDATA into even_pix; set even_pix_valid.
  - on an odd row, also issue the RAM read at address iX_Cont>>1.
- Odd column with even_pix_valid=1:
  - Even row (iY_Cont[0]=0): write {even_pix, iDATA} = {G1, R} to RAM[iX_Cont>>1]; set row_primed; clear even_pix_valid.
  - Odd row: {B, G2} = {even_pix, iDATA}; read data = {G1, R}; compute gray; clear even_pix_valid.
- Odd column with even_pix_valid=0: pixel dropped, no write, no output.
- Arithmetic: gray = (G1+R+B+G2) in a 14-bit sum, then [13:2]; truncation, no rounding.
- Latency and output timing:
  - Odd-row odd-column pixel sampled at edge N; oDATA/oX_Cont/oY_Cont update and oDVAL=1 at edge N+1.
  - oDVAL is low at edge N+2 unless another quad completes.
  - Throughput is at most one output per 2 accepted pixels.
- oDATA and the output coordinates hold their last value while oDVAL=0.
- Output suppression: no output while row_primed=0; i.e. the first odd row after reset produces nothing if no even row was seen.
- iDVAL gaps between the even and odd column of a pair are allowed; even_pix is held.
- A new even-column pixel overwrites even_pix (last even wins).
- Row change is seen via iY_Cont[0] on the odd pixel. A stale even_pix from the previous row is cleared when iX_Cont[0]=0 arrives; the bench confirms no output pairs across rows.
- RAM read/write to the same address on the same edge cannot occur: write is even rows only, read is odd rows only.
- Reset mid-row: pipe flushed, oDVAL=0 within the reset assertion; normal operation resumes from the next accepted even row.

Optional Feature:
- Macro GRAY_LUMA_EN.
- Defined: weighted luma gray = (4*R + 5*G1 + 5*G2 + 2*B) in a 16-bit sum, then [15:4]; truncation. Latency is unchanged (same single pipeline stage).
- Undefined: plain 4-pixel average as above.

Test Plan:
- Reset default: assert iRST=0 mid-stream -> oDVAL=0, oDATA=0, oX_Cont=oY_Cont=0 immediately (async); no output on the first odd row after release without a prior even row.
- Flat field: 4x4 frame, all pixels 12'h800, iDVAL=1 continuous.
  - Without macro: 2 oDVAL pulses on row 1 with oDATA=12'h800, coords (0,0),(1,0); 2 more on row 3 with coords (0,1),(1,1).
  - With GRAY_LUMA_EN: also 12'h800.
- Mixed quad: G1=100, R=200, B=300, G2=404.
  - Without macro: oDATA=251.
  - With GRAY_LUMA_EN: (800+500+2020+600)>>4=245.
  - Either way, oDVAL arrives exactly 1 edge after G2 is sampled.
- Max values: all 12'hFFF -> oDATA=12'hFFF, no overflow wrap, both modes.
- iDVAL gaps: 3 idle cycles between B and G2, and between G1 and R -> same oDATA as the gap-free run; oDVAL 1 edge after G2.
- Out of range and orphans: iX_Cont=LINE_WIDTH+2 with iDVAL=1 -> no RAM write, no oDVAL. An odd-column pixel with no preceding even pixel -> no oDVAL.
